i2c_master: RTL

Single-register I2C controller that issues register write and register read transactions to a 7-bit-addressed target such as the on-chip I2C slave. It converts one command on a valid/ready interface into a complete bus transaction, handles ACK/NACK and SCL clock stretching, and returns read data and status as a one-cycle response pulse. The block sits alongside the clock divider and synchronizers in the Tiny Tapeout top level and drives open-drain SCL/SDA pads through output-enable pins.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_quarter_timer.sv | 53 +++++
 rtl/i2c_master.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-access controller.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        TX_BIT,
        RX_ACK,
        RESTART,
        RX_BIT,
        TX_NACK,
        STOP,
        RESP
    } state_e;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-bit timebase: pulses q_tick at the end of each quarter and tracks
// the quarter phase within a bit cell. hold freezes the end of a quarter
// while the bus clock is being stretched.
module i2c_quarter_timer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       hold,
    output logic       q_tick,
    output logic [1:0] phase
);
    import i2c_pkg::*;

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic [1:0] phase_q, phase_d;

    // Count clocks within a quarter; the terminal count waits out any stretch.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        q_tick  = 1'b0;
        if (!enable) begin
            cnt_d   = '0;
            phase_d = Q0;
        end else if (cnt_q == LAST) begin
            if (!hold) begin
                q_tick  = 1'b1;
                cnt_d   = '0;
                phase_d = phase_q + 2'd1;
            end
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= Q0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/i2c_master.sv
// Single-register I2C controller: turns one write/read command into a full
// bus transaction on open-drain SCL/SDA and returns a one-cycle response.
module i2c_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);
    import i2c_pkg::*;

    state_e     state_q, state_d;
    logic       rw_q, rw_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic       nack_q, nack_d;
    logic       smp_q, smp_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rsp_nack_q, rsp_nack_d;
    logic [1:0] scl_sync_q, sda_sync_q;

    logic       timer_en, hold, q_tick, accept, q_end;
    logic [1:0] phase;

    assign cmd_ready = (state_q == IDLE) || (state_q == RESP);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_nack  = rsp_nack_q;
    assign accept    = cmd_valid && cmd_ready;
    assign timer_en  = (state_q != IDLE) && (state_q != RESP);
    assign hold      = ~scl_oe & ~scl_sync_q[1];
    assign q_end     = q_tick && (phase == Q3);

    i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (timer_en),
        .hold   (hold),
        .q_tick (q_tick),
        .phase  (phase)
    );

    // Double-flop pad synchronizers; idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
        end
    end

    // Next-state and datapath updates; every state advances on the last quarter.
    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        nack_d     = nack_q;
        smp_d      = smp_q;
        rdata_d    = rdata_q;
        rsp_nack_d = rsp_nack_q;
        if (q_tick && (phase == Q2)) begin
            smp_d = sda_sync_q[1];
        end
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    rw_d       = cmd_rw;
                    addr_d     = cmd_addr;
                    reg_d      = cmd_reg;
                    wdata_d    = cmd_wdata;
                    shreg_d    = {cmd_addr, I2C_WRITE};
                    bit_cnt_d  = '0;
                    byte_idx_d = '0;
                    nack_d     = 1'b0;
                    state_d    = START;
                end
            end
            START, RESTART: begin
                if (q_end) state_d = TX_BIT;
            end
            TX_BIT: begin
                if (q_end) begin
                    shreg_d   = {shreg_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_ACK;
                end
            end
            RX_ACK: begin
                if (q_end) begin
                    if (smp_q) begin
                        nack_d  = 1'b1;
                        state_d = STOP;
                    end else begin
                        case (byte_idx_q)
                            2'd0: begin
                                byte_idx_d = 2'd1;
                                shreg_d    = reg_q;
                                state_d    = TX_BIT;
                            end
                            2'd1: begin
                                byte_idx_d = 2'd2;
                                if (rw_q == I2C_READ) begin
                                    shreg_d = {addr_q, I2C_READ};
                                    state_d = RESTART;
                                end else begin
                                    shreg_d = wdata_q;
                                    state_d = TX_BIT;
                                end
                            end
                            default: state_d = (rw_q == I2C_READ) ? RX_BIT : STOP;
                        endcase
                    end
                end
            end
            RX_BIT: begin
                if (q_end) begin
                    shreg_d   = {shreg_q[6:0], smp_q};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = TX_NACK;
                end
            end
            TX_NACK: begin
                if (q_end) state_d = STOP;
            end
            STOP: begin
                if (q_end) begin
                    rdata_d    = ((rw_q == I2C_READ) && !nack_q) ? shreg_q : '0;
                    rsp_nack_d = nack_q;
                    state_d    = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pad drive from state and quarter phase; async reset releases both lines.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            START: sda_oe = phase[1];
            TX_BIT: begin
                scl_oe = ~phase[1];
                sda_oe = ~shreg_q[7];
            end
            RX_ACK, RX_BIT, TX_NACK: scl_oe = ~phase[1];
            RESTART: begin
                scl_oe = (phase == Q0);
                sda_oe = phase[1];
            end
            STOP: begin
                scl_oe = (phase == Q0);
                sda_oe = ~phase[1];
            end
            default: ;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rw_q       <= I2C_WRITE;
            addr_q     <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            nack_q     <= 1'b0;
            smp_q      <= 1'b1;
            rdata_q    <= '0;
            rsp_nack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            nack_q     <= nack_d;
            smp_q      <= smp_d;
            rdata_q    <= rdata_d;
            rsp_nack_q <= rsp_nack_d;
        end
    end

endmodule
